uart_rx_frame_ctrl: RTL
=======================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Sequences the byte stream from the UART receiver into framed packets: SYNC, LEN, payload, XOR checksum.
//  Writes payload bytes into an external byte buffer and hands each good frame to the consumer with a valid/ack handshake.
//  Rejects malformed, corrupted and stalled frames, then re-hunts for SYNC.
//  Sits between the UART receiver (byte + 1-cycle strobe) and the command/payload logic.
// PARAMETERS
//  SYNC_BYTE  8'hA5  frame start marker
//  MAX_LEN    16     max payload bytes per frame (1..255)
//  AW         4      buffer address width, >= clog2(MAX_LEN)
//  TIMEOUT    1000   idle clock cycles allowed between bytes inside a frame (>=2)
// PORTS
//  UART_clk     in   1   single clock, all logic rising-edge
//  rst_n        in   1   asynchronous, active-low reset
//  rx_byte      in   8   received byte, valid when rx_en=1
//  rx_en        in   1   one-cycle strobe per received byte
//  buf_we       out  1   payload buffer write enable (1 cycle per byte)
//  buf_addr     out  AW  payload buffer write address
//  buf_wdata    out  8   payload buffer write data
//  frame_valid  out  1   good frame in buffer; held until frame_ack
//  frame_len    out  8   payload length of held frame; stable while frame_valid=1
//  frame_ack    in   1   consumer done with buffer; sampled only while frame_valid=1
//  busy         out  1   1 whenever state != HUNT
//  chk_err      out  1   1-cycle pulse: checksum mismatch
//  len_err      out  1   1-cycle pulse: LEN==0 or LEN>MAX_LEN
//  timeout_err  out  1   1-cycle pulse: inter-byte timeout inside a frame
//  overrun      out  1   1-cycle pulse: byte arrived while frame held (byte dropped)
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All outputs 0.
//   - State HUNT; len, idx, chk and timer cleared.
//   - Reset mid-frame aborts immediately; buffer contents are then undefined.
//  Timing
//   - All outputs are registered.
//   - Every response appears in the cycle after the edge that sampled rx_en=1.
//  FSM states: HUNT, LEN, PAYLOAD, CHK, HOLD. Bytes are only acted on when rx_en=1.
//   - HUNT: byte==SYNC_BYTE -> LEN. Any other byte is ignored.
//   - LEN, byte==0 or byte>MAX_LEN: len_err pulse -> HUNT. A repeated SYNC_BYTE is treated as a length here.
//   - LEN, otherwise: len<=byte, chk<=byte, idx<=0 -> PAYLOAD.
//   - PAYLOAD: buf_we=1, buf_addr=idx[AW-1:0], buf_wdata=byte; chk<=chk^byte; idx<=idx+1.
//     Last payload byte (idx==len-1) -> CHK.
//   - CHK, byte==chk: frame_valid<=1, frame_len<=len -> HOLD.
//   - CHK, byte!=chk: chk_err pulse, frame_valid stays 0 -> HUNT.
//   - HOLD: frame_ack=1 sampled -> frame_valid 0 next cycle -> HUNT.
//     rx_en in HOLD: byte dropped, overrun pulse, frame_len unchanged.
//     rx_en and frame_ack in the same cycle: byte dropped with overrun, then -> HUNT.
//   - frame_ack outside HOLD is ignored.
//  Timeout (states LEN/PAYLOAD/CHK only)
//   - Timer is cleared on every rx_en and increments each cycle without rx_en.
//   - Reaching TIMEOUT-1 with no rx_en -> HUNT with timeout_err pulse.
//   - timeout_err appears TIMEOUT edges after the edge that accepted the last byte.
//   - rx_en in the expiry cycle wins: byte is processed, timer clears.
//   - Timer is frozen at 0 in HUNT and HOLD.
//  Checksum: 8-bit XOR of LEN and all payload bytes. SYNC is excluded.
//  buf_we is never asserted outside PAYLOAD. Error pulses never coincide with frame_valid rising.
// TESTING
//  1. A5 03 11 22 33 03 -> buf writes (0,11)(1,22)(2,33); frame_valid=1, frame_len=3; ack -> frame_valid=0, busy=0.
//  2. A5 03 11 22 33 04 -> chk_err single pulse; frame_valid stays 0; next good frame accepted.
//  3. A5 00 -> len_err. A5 11 (17>16) -> len_err. A5 A5 -> len_err. No buf_we in any case.
//  4. A5 02 11 then idle -> timeout_err exactly TIMEOUT edges after the 11 byte, state HUNT.
//     Same setup with the next byte arriving at edge TIMEOUT-1 -> no timeout.
//  5. 00 FF 5A A5 01 7E 7F -> leading bytes ignored; frame_len=1, buf(0)=7E.
//     While held, send 55 -> overrun pulse, frame_len still 1, buffer unchanged.
//  6. rst_n low for 1 cycle mid-payload -> all outputs 0 asynchronously; a following A5 01 7E 7F frame is accepted.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Turns the UART receiver's byte stream into framed packets of the form
//   SYNC, LEN, payload[LEN], XOR checksum. Payload bytes are written into an
//   external byte buffer. A good frame is held for the consumer until it
//   acknowledges with frame_ack. Malformed, corrupted and stalled frames are
//   rejected with a one-cycle error pulse, and the controller then hunts for
//   SYNC again.
// Ports
//   UART_clk    : single clock, rising edge
//   rst_n       : asynchronous active-low reset
//   rx_byte     : received byte, qualified by rx_en
//   rx_en       : one-cycle strobe per received byte
//   buf_we      : payload buffer write enable (one cycle per payload byte)
//   buf_addr    : payload buffer write address
//   buf_wdata   : payload buffer write data
//   frame_valid : good frame in buffer, held until frame_ack
//   frame_len   : payload length of the held frame
//   frame_ack   : consumer releases the buffer (only sampled while holding)
//   busy        : controller is anywhere other than hunting for SYNC
//   chk_err     : pulse, checksum mismatch
//   len_err     : pulse, LEN of zero or above MAX_LEN
//   timeout_err : pulse, inter-byte gap too long inside a frame
//   overrun     : pulse, byte dropped because a frame is being held
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic          UART_clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_byte,
    input  logic          rx_en,
    output logic          buf_we,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_wdata,
    output logic          frame_valid,
    output logic [7:0]    frame_len,
    input  logic          frame_ack,
    output logic          busy,
    output logic          chk_err,
    output logic          len_err,
    output logic          timeout_err,
    output logic          overrun
);

    localparam int unsigned TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    len, len_nxt;
    logic [7:0]    idx, idx_nxt;
    logic [7:0]    chk, chk_nxt;
    logic [TW-1:0] timer, timer_nxt;

    logic          buf_we_nxt;
    logic [AW-1:0] buf_addr_nxt;
    logic [7:0]    buf_wdata_nxt;
    logic          frame_valid_nxt;
    logic [7:0]    frame_len_nxt;
    logic          busy_nxt;
    logic          chk_err_nxt;
    logic          len_err_nxt;
    logic          timeout_err_nxt;
    logic          overrun_nxt;

    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HUNT;
            len         <= '0;
            idx         <= '0;
            chk         <= '0;
            timer       <= '0;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            busy        <= 1'b0;
            chk_err     <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            len         <= len_nxt;
            idx         <= idx_nxt;
            chk         <= chk_nxt;
            timer       <= timer_nxt;
            buf_we      <= buf_we_nxt;
            buf_addr    <= buf_addr_nxt;
            buf_wdata   <= buf_wdata_nxt;
            frame_valid <= frame_valid_nxt;
            frame_len   <= frame_len_nxt;
            busy        <= busy_nxt;
            chk_err     <= chk_err_nxt;
            len_err     <= len_err_nxt;
            timeout_err <= timeout_err_nxt;
            overrun     <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        len_nxt         = len;
        idx_nxt         = idx;
        chk_nxt         = chk;
        timer_nxt       = '0;
        buf_we_nxt      = 1'b0;
        buf_addr_nxt    = buf_addr;
        buf_wdata_nxt   = buf_wdata;
        frame_valid_nxt = frame_valid;
        frame_len_nxt   = frame_len;
        chk_err_nxt     = 1'b0;
        len_err_nxt     = 1'b0;
        timeout_err_nxt = 1'b0;
        overrun_nxt     = 1'b0;

        // Inter-byte timer only runs inside a frame; a byte in the expiry
        // cycle takes precedence because this branch requires !rx_en.
        if ((state == S_LEN || state == S_PAYLOAD || state == S_CHK) && !rx_en) begin
            if (timer == T_LAST) begin
                state_nxt       = S_HUNT;
                timeout_err_nxt = 1'b1;
            end else begin
                timer_nxt = timer + 1'b1;
            end
        end

        case (state)
            S_HUNT: begin
                if (rx_en && rx_byte == SYNC_BYTE)
                    state_nxt = S_LEN;
            end
            S_LEN: begin
                if (rx_en) begin
                    if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                        len_err_nxt = 1'b1;
                        state_nxt   = S_HUNT;
                    end else begin
                        len_nxt   = rx_byte;
                        chk_nxt   = rx_byte;
                        idx_nxt   = '0;
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_en) begin
                    buf_we_nxt    = 1'b1;
                    buf_addr_nxt  = AW'(idx);
                    buf_wdata_nxt = rx_byte;
                    chk_nxt       = chk ^ rx_byte;
                    idx_nxt       = idx + 8'd1;
                    if (idx == len - 8'd1)
                        state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_en) begin
                    if (rx_byte == chk) begin
                        frame_valid_nxt = 1'b1;
                        frame_len_nxt   = len;
                        state_nxt       = S_HOLD;
                    end else begin
                        chk_err_nxt = 1'b1;
                        state_nxt   = S_HUNT;
                    end
                end
            end
            S_HOLD: begin
                if (rx_en)
                    overrun_nxt = 1'b1;
                if (frame_ack) begin
                    frame_valid_nxt = 1'b0;
                    state_nxt       = S_HUNT;
                end
            end
            default: state_nxt = S_HUNT;
        endcase

        busy_nxt = (state_nxt != S_HUNT);
    end

endmodule
